// File: rtl/ram_port_arbiter_pkg.sv
// Shared definitions for the block-RAM port arbiter and its pick logic.
package ram_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = ST_IDLE,
    StAccess = ST_ACCESS,
    StWait   = ST_WAIT,
    StDone   = ST_DONE
  } arb_state_e;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DBG = 1'b1;

  localparam int unsigned RAM_RD_LATENCY = 1;

  // Round-robin partner of a two-port requester ID.
  function automatic logic other_port(input logic id);
    return ~id;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_pick.sv
// Combinational winner selection between the CPU and debug requesters.
module ram_arb_pick
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic cpu_req,
  input  logic dbg_req,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = cpu_req | dbg_req;
    winner = GNT_CPU;
    if (cpu_req && dbg_req) begin
      winner = (FIXED_PRIO != 0) ? GNT_CPU : other_port(last_grant);
    end else if (dbg_req) begin
      winner = GNT_DBG;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Serialises CPU and debug accesses onto the single-port 256-byte block RAM.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic              clk_qzt,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              grant_id
);

  arb_state_e state_q;
  logic       last_grant_q;
  logic       we_q;
  logic       pick_valid;
  logic       pick_winner;

  ram_arb_pick #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .cpu_req   (cpu_req),
    .dbg_req   (dbg_req),
    .last_grant(last_grant_q),
    .valid     (pick_valid),
    .winner    (pick_winner)
  );

  // ram_addr/ram_wdata double as the latched request; only ram_en qualifies them.
  always_ff @(posedge clk_qzt or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      last_grant_q <= GNT_DBG;
      we_q         <= 1'b0;
      grant_id     <= GNT_CPU;
      busy         <= 1'b0;
      ram_en       <= 1'b0;
      ram_we       <= 1'b0;
      ram_addr     <= '0;
      ram_wdata    <= '0;
      cpu_ack      <= 1'b0;
      dbg_ack      <= 1'b0;
      cpu_rdata    <= '0;
      dbg_rdata    <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dbg_ack <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            state_q  <= StAccess;
            busy     <= 1'b1;
            grant_id <= pick_winner;
            ram_en   <= 1'b1;
            if (pick_winner == GNT_DBG) begin
              we_q      <= dbg_we;
              ram_we    <= dbg_we;
              ram_addr  <= dbg_addr;
              ram_wdata <= dbg_wdata;
            end else begin
              we_q      <= cpu_we;
              ram_we    <= cpu_we;
              ram_addr  <= cpu_addr;
              ram_wdata <= cpu_wdata;
            end
          end
        end
        StAccess: begin
          ram_en  <= 1'b0;
          ram_we  <= 1'b0;
          state_q <= StWait;
        end
        StWait: begin
          // RAM output register holds the data one cycle after the address edge.
          if (!we_q) begin
            if (grant_id == GNT_DBG) dbg_rdata <= ram_rdata;
            else                     cpu_rdata <= ram_rdata;
          end
          state_q <= StDone;
        end
        StDone: begin
          if (grant_id == GNT_DBG) dbg_ack <= 1'b1;
          else                     cpu_ack <= 1'b1;
          last_grant_q <= grant_id;
          busy         <= 1'b0;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench with ack scoreboard for round-robin and fixed-priority arbiters.
module tb_ram_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        id;
    logic        rd;
    logic [7:0]  data;
    int unsigned at;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  logic [1:0]      rst_n, c_req, c_we, d_req, d_we;
  logic [1:0][7:0] c_addr, c_wd, d_addr, d_wd;
  logic [1:0]      c_ack, d_ack, en, we, busy, gid;
  logic [1:0][7:0] crd, drd, addr, wd;
  logic [7:0]      rd0, rd1;
  logic [7:0]      mem0 [256];
  logic [7:0]      mem1 [256];

  logic [1:0]      pa0, pa1;
  int              en_cnt0;
  logic [7:0]      l_addr, l_wd;
  logic            l_we;

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) u_dut0 (
    .clk_qzt(clk), .reset_n(rst_n[0]),
    .cpu_req(c_req[0]), .cpu_we(c_we[0]), .cpu_addr(c_addr[0]), .cpu_wdata(c_wd[0]),
    .cpu_ack(c_ack[0]), .cpu_rdata(crd[0]),
    .dbg_req(d_req[0]), .dbg_we(d_we[0]), .dbg_addr(d_addr[0]), .dbg_wdata(d_wd[0]),
    .dbg_ack(d_ack[0]), .dbg_rdata(drd[0]),
    .ram_en(en[0]), .ram_we(we[0]), .ram_addr(addr[0]), .ram_wdata(wd[0]),
    .ram_rdata(rd0), .busy(busy[0]), .grant_id(gid[0])
  );

  ram_port_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) u_dut1 (
    .clk_qzt(clk), .reset_n(rst_n[1]),
    .cpu_req(c_req[1]), .cpu_we(c_we[1]), .cpu_addr(c_addr[1]), .cpu_wdata(c_wd[1]),
    .cpu_ack(c_ack[1]), .cpu_rdata(crd[1]),
    .dbg_req(d_req[1]), .dbg_we(d_we[1]), .dbg_addr(d_addr[1]), .dbg_wdata(d_wd[1]),
    .dbg_ack(d_ack[1]), .dbg_rdata(drd[1]),
    .ram_en(en[1]), .ram_we(we[1]), .ram_addr(addr[1]), .ram_wdata(wd[1]),
    .ram_rdata(rd1), .busy(busy[1]), .grant_id(gid[1])
  );

  // Registered-output block RAM models.
  always @(posedge clk) begin
    if (en[0]) begin
      if (we[0]) mem0[addr[0]] <= wd[0];
      rd0 <= mem0[addr[0]];
    end
  end

  always @(posedge clk) begin
    if (en[1]) begin
      if (we[1]) mem1[addr[1]] <= wd[1];
      rd1 <= mem1[addr[1]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon(input int inst, input logic ca, input logic da,
                     input logic [7:0] crdv, input logic [7:0] drdv);
    exp_t       e;
    logic [1:0] prev;
    prev = (inst == 0) ? pa0 : pa1;
    if (inst == 0) pa0 = {da, ca};
    else           pa1 = {da, ca};
    if (!(ca || da)) return;
    check("ack_onehot", {31'd0, ca & da}, 0);
    check("ack_width", {31'd0, (ca & prev[0]) | (da & prev[1])}, 0);
    if ((inst == 0 && sb0.size() == 0) || (inst == 1 && sb1.size() == 0)) begin
      check("unexpected_ack", {30'd0, da, ca}, 0);
      return;
    end
    e = (inst == 0) ? sb0.pop_front() : sb1.pop_front();
    check("ack_port", {31'd0, da}, {31'd0, e.id});
    check("ack_cycle", cyc, e.at);
    if (e.rd) check("rdata", {24'd0, e.id ? drdv : crdv}, {24'd0, e.data});
  endtask

  task automatic tick();
    @(negedge clk);
    mon(0, c_ack[0], d_ack[0], crd[0], drd[0]);
    mon(1, c_ack[1], d_ack[1], crd[1], drd[1]);
    if (en[0]) begin
      en_cnt0++;
      l_addr = addr[0];
      l_we   = we[0];
      l_wd   = wd[0];
    end
    if (we[0] && !en[0]) check("ram_we_no_en0", {31'd0, we[0]}, {31'd0, en[0]});
    if (we[1] && !en[1]) check("ram_we_no_en1", {31'd0, we[1]}, {31'd0, en[1]});
  endtask

  task automatic wait_ack(input int inst, input logic port);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      got = port ? d_ack[inst] : c_ack[inst];
    end
    if (!got) check("ack_timeout", {31'd0, got}, 1);
  endtask

  task automatic push0(input logic id, input logic rd, input logic [7:0] data,
                       input int unsigned at);
    exp_t e;
    e.id = id; e.rd = rd; e.data = data; e.at = at;
    sb0.push_back(e);
  endtask

  // Single transaction on dut0 from the given port; req dropped in the ack cycle.
  task automatic txn0(input logic port, input logic w, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] rexp);
    push0(port, !w, rexp, cyc + 4);
    if (port) begin
      d_req[0] = 1'b1; d_we[0] = w; d_addr[0] = a; d_wd[0] = d;
    end else begin
      c_req[0] = 1'b1; c_we[0] = w; c_addr[0] = a; c_wd[0] = d;
    end
    wait_ack(0, port);
    if (port) d_req[0] = 1'b0;
    else      c_req[0] = 1'b0;
  endtask

  task automatic check_reset_outs(input int i, input string tag);
    check({tag, "_ctrl"}, {24'd0, c_ack[i], d_ack[i], en[i], we[i], busy[i], gid[i], 2'b00}, 0);
    check({tag, "_data"}, {crd[i], drd[i], addr[i], wd[i]}, 0);
  endtask

  initial begin
    int base;
    exp_t e;
    rst_n = '0; c_req = '0; c_we = '0; d_req = '0; d_we = '0;
    c_addr = '0; c_wd = '0; d_addr = '0; d_wd = '0;
    pa0 = '0; pa1 = '0; en_cnt0 = 0; l_addr = '0; l_wd = '0; l_we = 1'b0;

    tick(); tick();
    check_reset_outs(0, "reset0");
    check_reset_outs(1, "reset1");
    rst_n = 2'b11;
    tick();

    // CPU write 10 <= A5
    base = en_cnt0;
    txn0(1'b0, 1'b1, 8'h10, 8'hA5, 8'h00);
    check("wr_en_count", en_cnt0 - base, 1);
    check("wr_ram_we", {31'd0, l_we}, 1);
    check("wr_ram_addr", {24'd0, l_addr}, 32'h10);
    check("wr_ram_wdata", {24'd0, l_wd}, 32'hA5);

    // Debug read-back of 10; CPU read data untouched
    txn0(1'b1, 1'b0, 8'h10, 8'h00, 8'hA5);
    check("cpu_rdata_kept", {24'd0, crd[0]}, 0);

    // Address change while busy must not affect the in-flight read
    txn0(1'b0, 1'b1, 8'h20, 8'h3C, 8'h00);
    txn0(1'b0, 1'b1, 8'h30, 8'hC3, 8'h00);
    base = en_cnt0;
    push0(1'b0, 1'b1, 8'h3C, cyc + 4);
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 8'h20;
    tick(); tick();
    c_addr[0] = 8'h30;
    wait_ack(0, 1'b0);
    c_req[0] = 1'b0;
    check("busy_chg_en_count", en_cnt0 - base, 1);
    check("busy_chg_addr", {24'd0, l_addr}, 32'h20);

    // Round-robin from reset: CPU, DBG, CPU with both held
    rst_n[0] = 1'b0;
    tick();
    rst_n[0] = 1'b1;
    tick();
    base = en_cnt0;
    push0(1'b0, 1'b1, 8'hA5, cyc + 4);
    push0(1'b1, 1'b1, 8'h3C, cyc + 8);
    push0(1'b0, 1'b1, 8'hA5, cyc + 12);
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 8'h10;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h20;
    wait_ack(0, 1'b0);
    wait_ack(0, 1'b1);
    wait_ack(0, 1'b0);
    c_req[0] = 1'b0; d_req[0] = 1'b0;
    check("rr_en_count", en_cnt0 - base, 3);
    tick();

    // Reset during WAIT of a read: outputs clear at once, no ack, CPU wins afterwards
    c_req[0] = 1'b1; c_we[0] = 1'b0; c_addr[0] = 8'h20;
    tick(); tick();
    rst_n[0] = 1'b0;
    #1;
    check_reset_outs(0, "async_reset");
    c_addr[0] = 8'h10;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h20;
    tick(); tick();
    check("no_ack_in_reset", {30'd0, d_ack[0], c_ack[0]}, 0);
    rst_n[0] = 1'b1;
    push0(1'b0, 1'b1, 8'hA5, cyc + 4);
    wait_ack(0, 1'b0);
    c_req[0] = 1'b0; d_req[0] = 1'b0;
    tick(); tick(); tick(); tick();

    // Fixed priority: CPU held high starves the debug port
    for (int k = 0; k < 4; k++) begin
      e.id = 1'b0; e.rd = 1'b0; e.data = 8'h00; e.at = cyc + 4 + 4 * k;
      sb1.push_back(e);
    end
    c_req[1] = 1'b1; c_we[1] = 1'b1; c_addr[1] = 8'h40; c_wd[1] = 8'h11;
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 8'h50; d_wd[1] = 8'h22;
    for (int k = 0; k < 4; k++) wait_ack(1, 1'b0);
    c_req[1] = 1'b0; d_req[1] = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("fixed_mem_write", {24'd0, mem1[8'h40]}, 32'h11);
    check("fixed_sb_empty", sb1.size(), 0);
    check("rr_sb_empty", sb0.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
